// File: rtl/dcache_lb_bridge_if.sv
// Bus interfaces for dcache_lb_bridge.
//   dcache_lb_refill_if : cache controller refill port (master = cache, slave = bridge)
//   dcache_lb_mem_if    : 64-bit DRAM-side beat bus  (master = bridge, slave = memory)

interface dcache_lb_refill_if;
  logic         req;
  logic         gnt;
  logic         we;
  logic [11:0]  addr;
  logic         addr_valid;
  logic         addr_ready;
  logic         wvalid;
  logic [255:0] wdata;
  logic         rvalid;
  logic [255:0] rdata;

  modport master (
    output req, we, addr, addr_valid, wvalid, wdata,
    input  gnt, addr_ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, addr_valid, wvalid, wdata,
    output gnt, addr_ready, rvalid, rdata
  );
endinterface

interface dcache_lb_mem_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [13:0] addr;
  logic [63:0] wdata;
  logic        rvalid;
  logic [63:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dcache_lb_bridge.sv
// dcache_lb_bridge: converts one 256-bit cache line transaction (writeback or
// refill) into four 64-bit beats on a req/gnt memory bus with in-order,
// variable-latency read returns. Refill beats are reassembled in a local line
// buffer and handed back to the cache as a single 256-bit pulse.
// Optional feature: define DCACHE_LB_PERF_EN to add saturating 32-bit
// performance counters (perf_rd_cnt, perf_wr_cnt, perf_stall_cnt).

module dcache_lb_bridge #(
  parameter int BEATS  = 4,
  parameter int MEM_AW = 14
) (
  input  logic                clk,
  input  logic                rst,
  dcache_lb_refill_if.slave   dcache_refill,
  dcache_lb_mem_if.master     mem,
  output logic                busy
`ifdef DCACHE_LB_PERF_EN
  ,
  output logic [31:0]         perf_rd_cnt,
  output logic [31:0]         perf_wr_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int CntW   = $clog2(BEATS);
  localparam int LineAw = MEM_AW - CntW;
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_t;

  state_t              r_state;
  logic                r_we;
  logic [LineAw-1:0]   r_lineAddr;
  logic [CntW-1:0]     r_issueCnt;
  logic [CntW-1:0]     r_retCnt;
  logic [255:0]        r_lineBuf;

  logic                w_issuing;
  logic                w_retAccept;

  assign w_issuing   = (r_state == WR_ISSUE) || (r_state == RD_ISSUE);
  assign w_retAccept = mem.rvalid && ((r_state == RD_ISSUE) || (r_state == RD_WAIT));

  // Outputs decode straight from registered state; rst forces them quiet so the
  // bus is idle during the reset cycle itself, not just after it.
  assign dcache_refill.gnt        = !rst && (r_state == IDLE) && dcache_refill.req;
  assign dcache_refill.addr_ready = !rst && (r_state == ADDR);
  assign dcache_refill.rvalid     = !rst && (r_state == RESP);
  assign dcache_refill.rdata      = rst ? '0 : r_lineBuf;
  assign mem.req                  = !rst && w_issuing;
  assign mem.we                   = !rst && (r_state == WR_ISSUE);
  assign mem.addr                 = rst ? '0 : {r_lineAddr, r_issueCnt};
  assign mem.wdata                = rst ? '0 : r_lineBuf[{r_issueCnt, 6'b0} +: 64];
  assign busy                     = !rst && (r_state != IDLE);

  // Transaction FSM: accepts a line, issues four beats, and gathers read returns
  // (which may overlap issuing) into the line buffer before answering the cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_lineAddr <= '0;
      r_issueCnt <= '0;
      r_retCnt   <= '0;
      r_lineBuf  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (dcache_refill.req) begin
            r_we    <= dcache_refill.we;
            r_state <= ADDR;
          end
        end
        ADDR: begin
          if (dcache_refill.addr_valid) begin
            r_lineAddr <= dcache_refill.addr;
            r_issueCnt <= '0;
            r_retCnt   <= '0;
            r_state    <= r_we ? WDATA : RD_ISSUE;
          end
        end
        WDATA: begin
          if (dcache_refill.wvalid) begin
            r_lineBuf <= dcache_refill.wdata;
            r_state   <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          if (mem.gnt) begin
            r_issueCnt <= r_issueCnt + 1'b1;
            if (r_issueCnt == LastBeat) begin
              r_state <= IDLE;
            end
          end
        end
        RD_ISSUE, RD_WAIT: begin
          if ((r_state == RD_ISSUE) && mem.gnt) begin
            r_issueCnt <= r_issueCnt + 1'b1;
            if (r_issueCnt == LastBeat) begin
              r_state <= RD_WAIT;
            end
          end
          if (w_retAccept) begin
            r_lineBuf[{r_retCnt, 6'b0} +: 64] <= mem.rdata;
            r_retCnt <= r_retCnt + 1'b1;
            if (r_retCnt == LastBeat) begin
              r_state <= RESP;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef DCACHE_LB_PERF_EN
  // Saturating event counters for completed refills, completed writebacks and
  // cycles the memory bus held off a pending beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_cnt    <= '0;
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_retAccept && (r_retCnt == LastBeat) && (perf_rd_cnt != 32'hFFFF_FFFF)) begin
        perf_rd_cnt <= perf_rd_cnt + 32'd1;
      end
      if ((r_state == WR_ISSUE) && mem.gnt && (r_issueCnt == LastBeat) &&
          (perf_wr_cnt != 32'hFFFF_FFFF)) begin
        perf_wr_cnt <= perf_wr_cnt + 32'd1;
      end
      if (w_issuing && !mem.gnt && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_lb_bridge.sv
// Self-checking bench for dcache_lb_bridge: a vector table of line transactions
// plus hand-written sequences for busy blocking and reset during a refill.
// A small memory model answers beats; expected beats and lines are queued when
// a transaction is driven and popped as the DUT produces them.

module tb_dcache_lb_bridge;

  logic clk;
  logic rst;
  logic busy;
`ifdef DCACHE_LB_PERF_EN
  logic [31:0] perf_rd_cnt;
  logic [31:0] perf_wr_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  dcache_lb_refill_if refillIf ();
  dcache_lb_mem_if    memIf ();

  dcache_lb_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .dcache_refill (refillIf),
    .mem           (memIf),
    .busy          (busy)
`ifdef DCACHE_LB_PERF_EN
    ,
    .perf_rd_cnt   (perf_rd_cnt),
    .perf_wr_cnt   (perf_wr_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index, advanced on every rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] beat;
    int         due;
  } ret_t;

  typedef struct {
    bit           we;
    logic [11:0]  addr;
    logic [255:0] line;
    int           lat;
    int           stallBeat;
    int           stallCyc;
    logic [13:0]  expBase;
    int           expLat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [77:0]  wrQ[$];
  logic [13:0]  rdAddrQ[$];
  logic [255:0] rdQ[$];
  ret_t         pendQ[$];
  logic [63:0]  retData[4];

  int  lat = 1;
  int  stallBeat = -1;
  int  stallLeft = 0;
  bit  stray = 1'b0;
  int  gntCyc = 0;
  int  rvCyc = 0;
  int  lastWrCyc = 0;
  int  rvCount = 0;
  bit  holdValid = 1'b0;
  logic [13:0] holdAddr;
  logic [63:0] holdData;
  logic        holdWe;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on write beats, read requests and refill pulses
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pendQ.delete();
        holdValid = 1'b0;
      end else begin
        if (holdValid && memIf.req) begin
          checkOutput("holdAddr", 256'(memIf.addr), 256'(holdAddr));
          checkOutput("holdWdata", 256'(memIf.wdata), 256'(holdData));
          checkOutput("holdWe", 256'(memIf.we), 256'(holdWe));
        end
        holdValid = memIf.req && !memIf.gnt;
        holdAddr  = memIf.addr;
        holdData  = memIf.wdata;
        holdWe    = memIf.we;
        if (memIf.req && memIf.gnt) begin
          if (memIf.we) begin
            if (wrQ.size() == 0) begin
              checkOutput("unexpectedWrite", 256'(memIf.addr), 256'(0));
            end else begin
              logic [77:0] e;
              e = wrQ.pop_front();
              checkOutput("wrBeat", 256'({memIf.addr, memIf.wdata}), 256'(e));
            end
            if (memIf.addr[1:0] == 2'd3) lastWrCyc = cyc;
          end else begin
            ret_t r;
            if (rdAddrQ.size() == 0) begin
              checkOutput("unexpectedRead", 256'(memIf.addr), 256'(0));
            end else begin
              logic [13:0] a;
              a = rdAddrQ.pop_front();
              checkOutput("rdAddr", 256'(memIf.addr), 256'(a));
            end
            r.beat = memIf.addr[1:0];
            r.due  = cyc + lat;
            pendQ.push_back(r);
          end
        end
      end
      if (refillIf.rvalid) begin
        rvCount++;
        rvCyc = cyc;
        if (rdQ.size() == 0) begin
          checkOutput("unexpectedRvalid", 256'(1'b1), 256'(1'b0));
        end else begin
          logic [255:0] l;
          l = rdQ.pop_front();
          checkOutput("rdata", refillIf.rdata, l);
        end
      end
      if (refillIf.gnt) gntCyc = cyc;
    end
  end

  // Memory model driver: grant with optional stall, in-order returns after latency
  initial begin
    memIf.gnt    = 1'b1;
    memIf.rvalid = 1'b0;
    memIf.rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stallLeft > 0 && memIf.req && int'(memIf.addr[1:0]) == stallBeat) begin
        memIf.gnt = 1'b0;
        stallLeft--;
      end else begin
        memIf.gnt = 1'b1;
      end
      if (stray) begin
        memIf.rvalid = 1'b1;
        memIf.rdata  = '1;
      end else if (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
        ret_t r;
        r = pendQ.pop_front();
        memIf.rvalid = 1'b1;
        memIf.rdata  = retData[r.beat];
      end else begin
        memIf.rvalid = 1'b0;
        memIf.rdata  = '0;
      end
    end
  end

  // Drives one transaction through grant, address and (for writebacks) data
  task automatic applyStimulus(input bit we, input logic [11:0] addr, input logic [255:0] line,
                               input logic [13:0] expBase, input bit expectResp);
    bit granted = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (we) wrQ.push_back({expBase + 14'(i), line[i*64 +: 64]});
      else begin
        rdAddrQ.push_back(expBase + 14'(i));
        retData[i] = line[i*64 +: 64];
      end
    end
    if (!we && expectResp) rdQ.push_back(line);
    @(posedge clk);
    #1;
    refillIf.req = 1'b1;
    refillIf.we  = we;
    for (int n = 0; n < 50 && !granted; n++) begin
      @(negedge clk);
      if (refillIf.gnt) granted = 1'b1;
    end
    checkOutput("grantTimeout", 256'(granted), 256'(1'b1));
    @(posedge clk);
    #1;
    refillIf.req        = 1'b0;
    refillIf.addr_valid = 1'b1;
    refillIf.addr       = addr;
    @(negedge clk);
    checkOutput("addrReady", 256'(refillIf.addr_ready), 256'(1'b1));
    @(posedge clk);
    #1;
    refillIf.addr_valid = 1'b0;
    if (we) begin
      refillIf.wvalid = 1'b1;
      refillIf.wdata  = line;
      @(posedge clk);
      #1;
      refillIf.wvalid = 1'b0;
    end
  endtask

  task automatic waitIdle(output int idleCyc);
    bit done = 1'b0;
    idleCyc = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        idleCyc = cyc;
      end
    end
    checkOutput("idleTimeout", 256'(done), 256'(1'b1));
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t vecs[6];

  initial begin
    int idleCyc;
    int rvBefore;
    bit gntWhileBusy;
    bit sawIdle;
    bit inWait;
`ifdef DCACHE_LB_PERF_EN
    logic [31:0] perfRd0, perfWr0, perfSt0;
`endif

    vecs[0] = '{1'b1, 12'hABC, {64'h4, 64'h3, 64'h2, 64'h1}, 1, -1, 0, 14'h2AF0, 6};
    vecs[1] = '{1'b0, 12'h005, {64'h44, 64'h33, 64'h22, 64'h11}, 3, -1, 0, 14'h0014, 9};
    vecs[2] = '{1'b1, 12'h123, {64'hDEAD_BEEF_0000_0003, 64'hCAFE_F00D_0000_0002,
                                64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210}, 1, 2, 5, 14'h048C, -1};
    vecs[3] = '{1'b0, 12'hFFF, {64'hA4A4_0000_1111_0004, 64'hA3A3_0000_1111_0003,
                                64'hA2A2_0000_1111_0002, 64'hA1A1_0000_1111_0001}, 1, 2, 5, 14'h3FFC, -1};
    vecs[4] = '{1'b0, 12'h800, {64'h0BAD_F00D_4444_4444, 64'h0BAD_F00D_3333_3333,
                                64'h0BAD_F00D_2222_2222, 64'h0BAD_F00D_1111_1111}, 1, -1, 0, 14'h2000, 7};
    vecs[5] = '{1'b1, 12'h000, {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                                64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000}, 1, -1, 0, 14'h0000, 6};

    refillIf.req        = 1'b1;
    refillIf.we         = 1'b0;
    refillIf.addr       = '0;
    refillIf.addr_valid = 1'b1;
    refillIf.wvalid     = 1'b0;
    refillIf.wdata      = '0;
    rst                 = 1'b1;

    // Reset: outputs quiet even with req/addr_valid asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstGnt", 256'(refillIf.gnt), 256'(1'b0));
    checkOutput("rstAddrReady", 256'(refillIf.addr_ready), 256'(1'b0));
    checkOutput("rstRvalid", 256'(refillIf.rvalid), 256'(1'b0));
    checkOutput("rstMemReq", 256'(memIf.req), 256'(1'b0));
    checkOutput("rstMemWe", 256'(memIf.we), 256'(1'b0));
    checkOutput("rstMemAddr", 256'(memIf.addr), 256'(0));
    checkOutput("rstMemWdata", 256'(memIf.wdata), 256'(0));
    checkOutput("rstRdata", refillIf.rdata, 256'(0));
    checkOutput("rstBusy", 256'(busy), 256'(1'b0));
    refillIf.req        = 1'b0;
    refillIf.addr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven transactions
    foreach (vecs[v]) begin
      lat       = vecs[v].lat;
      stallBeat = vecs[v].stallBeat;
      stallLeft = vecs[v].stallCyc;
`ifdef DCACHE_LB_PERF_EN
      perfRd0 = perf_rd_cnt;
      perfWr0 = perf_wr_cnt;
      perfSt0 = perf_stall_cnt;
`endif
      applyStimulus(vecs[v].we, vecs[v].addr, vecs[v].line, vecs[v].expBase, 1'b1);
      waitIdle(idleCyc);
      if (vecs[v].we) begin
        if (vecs[v].expLat >= 0)
          checkOutput("wrLatency", 256'(lastWrCyc - gntCyc), 256'(vecs[v].expLat));
      end else begin
        checkOutput("busyAfterResp", 256'(idleCyc - rvCyc), 256'(1));
        checkOutput("rdataHold", refillIf.rdata, vecs[v].line);
        if (vecs[v].expLat >= 0)
          checkOutput("rdLatency", 256'(rvCyc - gntCyc), 256'(vecs[v].expLat));
      end
      checkOutput("pendingBeats", 256'(wrQ.size() + rdAddrQ.size() + rdQ.size()), 256'(0));
`ifdef DCACHE_LB_PERF_EN
      checkOutput("perfStall", 256'(perf_stall_cnt - perfSt0), 256'(vecs[v].stallCyc));
      checkOutput("perfRd", 256'(perf_rd_cnt - perfRd0), 256'(vecs[v].we ? 0 : 1));
      checkOutput("perfWr", 256'(perf_wr_cnt - perfWr0), 256'(vecs[v].we ? 1 : 0));
`endif
    end
    stallBeat = -1;
    stallLeft = 0;

    // Busy: a request held during a refill is only granted once back in IDLE
    lat = 6;
    applyStimulus(1'b0, 12'h0AA, {64'hD4, 64'hC3, 64'hB2, 64'hA1}, 14'h02A8, 1'b1);
    refillIf.req = 1'b1;
    refillIf.we  = 1'b1;
    gntWhileBusy = 1'b0;
    sawIdle      = 1'b0;
    for (int n = 0; n < 100 && !sawIdle; n++) begin
      @(negedge clk);
      if (busy) begin
        if (refillIf.gnt) gntWhileBusy = 1'b1;
      end else begin
        sawIdle = 1'b1;
        checkOutput("gntInIdle", 256'(refillIf.gnt), 256'(1'b1));
        refillIf.req = 1'b0;
      end
    end
    refillIf.req = 1'b0;
    checkOutput("busyReturnsIdle", 256'(sawIdle), 256'(1'b1));
    checkOutput("noGntWhileBusy", 256'(gntWhileBusy), 256'(1'b0));
    @(negedge clk);
    checkOutput("noGrantAfterDrop", 256'(busy), 256'(1'b0));

    // Reset while waiting for read returns, then stray returns in IDLE
    lat = 30;
    rvBefore = rvCount;
    applyStimulus(1'b0, 12'h3C3, {64'h8, 64'h7, 64'h6, 64'h5}, 14'h0F0C, 1'b0);
    inWait = 1'b0;
    for (int n = 0; n < 20 && !inWait; n++) begin
      @(negedge clk);
      if (busy && !memIf.req && !refillIf.addr_ready) inWait = 1'b1;
    end
    checkOutput("reachedRdWait", 256'(inWait), 256'(1'b1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstMidMemReq", 256'(memIf.req), 256'(1'b0));
    @(posedge clk);
    #1;
    rst   = 1'b0;
    stray = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stray = 1'b0;
    @(negedge clk);
    checkOutput("abortBusy", 256'(busy), 256'(1'b0));
    checkOutput("abortRdata", refillIf.rdata, 256'(0));
    checkOutput("abortNoRvalid", 256'(rvCount - rvBefore), 256'(0));
    checkOutput("queuesEmpty", 256'(wrQ.size() + rdAddrQ.size() + rdQ.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
